// File: rtl/mcycle_pkg.sv
// mcycle_pkg: S-state encodings and cycle-count width helper
// shared by the machine-cycle sequencer and its bench.
package mcycle_pkg;

  typedef enum logic [2:0] {
    S1 = 3'b001,
    S2 = 3'b011,
    S3 = 3'b010,
    S4 = 3'b000,
    S5 = 3'b100,
    S6 = 3'b101
  } state_t;

  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcycle_prescaler.sv
// mcycle_prescaler: divides clk into phase ticks.
// Ports: clk, reset (sync, high) in; tick out (last clk of a phase).
module mcycle_prescaler #(
  parameter int CLK_PER_PHASE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW =
    (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_PHASE - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == LAST);

endmodule

// File: rtl/mcycle_seq.sv
// mcycle_seq: S1..S6 / P1-P2 machine-cycle sequencer with ALE/PSEN.
// In: clk, reset (sync, high), decode_valid, cycles_decoded, movx,
//   ready. Out: phase, state, cyc_left, first_cyc, state_tick,
//   instr_start, ale, psen (low), stalled, wait_timeout.
// Wait states on S3/S6 exist only with MCYCLE_WAIT_STATE_EN.
module mcycle_seq
  import mcycle_pkg::*;
#(
  parameter int CLK_PER_PHASE = 1,
  parameter int MAX_CYCLES    = 4,
  parameter int WAIT_MAX      = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          decode_valid,
  input  logic [cw_of(MAX_CYCLES)-1:0]  cycles_decoded,
  input  logic                          movx,
  input  logic                          ready,
  output logic                          phase,
  output logic [2:0]                    state,
  output logic [cw_of(MAX_CYCLES)-1:0]  cyc_left,
  output logic                          first_cyc,
  output logic                          state_tick,
  output logic                          instr_start,
  output logic                          ale,
  output logic                          psen,
  output logic                          stalled,
  output logic                          wait_timeout
);

  localparam int CW = cw_of(MAX_CYCLES);
  localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYCLES - 1);

  logic          tick;
  state_t        st;
  state_t        st_n;
  logic          ph_n;
  logic          first_n;
  logic [CW-1:0] left_n;
  logic          adv;
  logic          ale_n;
  logic          psen_n;
  logic          strobe1;
  logic          strobe2;

  mcycle_prescaler #(
    .CLK_PER_PHASE(CLK_PER_PHASE)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

`ifdef MCYCLE_WAIT_STATE_EN
  localparam int WW =
    (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WLIM = WW'(WAIT_MAX);

  logic [WW-1:0] wcnt;
  logic          hold;
  logic          timeout;
`endif

  always_comb begin
    st_n    = st;
    ph_n    = phase;
    first_n = first_cyc;
    left_n  = cyc_left;
    adv     = tick & phase;
`ifdef MCYCLE_WAIT_STATE_EN
    hold    = 1'b0;
    timeout = 1'b0;
    if (adv && (st == S3 || st == S6) && !ready) begin
      if (wcnt < WLIM) begin
        adv  = 1'b0;
        hold = 1'b1;
      end else begin
        timeout = 1'b1;
      end
    end
`endif
    if (tick) begin
      ph_n = ~phase;
    end
    if (tick && phase && st == S1 && first_cyc) begin
      if (!decode_valid) begin
        left_n = '0;
      end else if (cycles_decoded > LAST_CYC) begin
        left_n = LAST_CYC;
      end else begin
        left_n = cycles_decoded;
      end
    end
    if (adv) begin
      unique case (st)
        S1:      st_n = S2;
        S2:      st_n = S3;
        S3:      st_n = S4;
        S4:      st_n = S5;
        S5:      st_n = S6;
        S6:      st_n = S1;
        default: st_n = S1;
      endcase
      if (st == S6) begin
        if (cyc_left == '0) begin
          first_n = 1'b1;
        end else begin
          left_n  = cyc_left - 1'b1;
          first_n = 1'b0;
        end
      end
    end
    // Strobes are computed from the next state so the
    // registered outputs line up with state, no extra clk.
    ale_n = (st_n == S4) ||
            (st_n == S1 &&
             !(movx && !first_n && left_n == '0));
    strobe1 = ((st_n == S2 && ph_n) || st_n == S3) &&
              !(movx && !first_n);
    strobe2 = ((st_n == S5 && ph_n) || st_n == S6) &&
              !(movx && first_n && left_n != '0);
    psen_n = ~(strobe1 | strobe2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S6;
      phase       <= 1'b0;
      cyc_left    <= '0;
      first_cyc   <= 1'b0;
      state_tick  <= 1'b0;
      instr_start <= 1'b0;
      ale         <= 1'b0;
      psen        <= 1'b1;
    end else begin
      st          <= st_n;
      phase       <= ph_n;
      cyc_left    <= left_n;
      first_cyc   <= first_n;
      state_tick  <= adv;
      instr_start <= adv && st_n == S1 && first_n;
      ale         <= ale_n;
      psen        <= psen_n;
    end
  end

  assign state = st;

`ifdef MCYCLE_WAIT_STATE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt         <= '0;
      stalled      <= 1'b0;
      wait_timeout <= 1'b0;
    end else begin
      wait_timeout <= timeout;
      if (hold) begin
        wcnt    <= wcnt + 1'b1;
        stalled <= 1'b1;
      end else if (adv) begin
        wcnt    <= '0;
        stalled <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = ready ^ WAIT_MAX[0];
  assign stalled      = 1'b0;
  assign wait_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mcycle_seq.sv
// tb_mcycle_seq: model-checked bench for mcycle_seq,
// two instances (CLK_PER_PHASE 1 and 3) plus directed checks.
module tb_mcycle_seq;

  localparam int MAXC = 4;
  localparam int WMAX = 15;
  localparam int CW   = 2;
`ifdef MCYCLE_WAIT_STATE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, dv1, mx1, rdy1, rst3;
  logic [CW-1:0] cd1;
  logic          ph1, fc1, stk1, is1, ale1, ps1, sl1, wt1;
  logic [2:0]    s1;
  logic [CW-1:0] cl1;
  logic          ph3, fc3, stk3, is3, ale3, ps3, sl3, wt3;
  logic [2:0]    s3;
  logic [CW-1:0] cl3;

  int total = 0;
  int bad   = 0;

  mcycle_seq #(
    .CLK_PER_PHASE(1), .MAX_CYCLES(MAXC), .WAIT_MAX(WMAX)
  ) dut1 (
    .clk(clk), .reset(rst1), .decode_valid(dv1),
    .cycles_decoded(cd1), .movx(mx1), .ready(rdy1),
    .phase(ph1), .state(s1), .cyc_left(cl1),
    .first_cyc(fc1), .state_tick(stk1),
    .instr_start(is1), .ale(ale1), .psen(ps1),
    .stalled(sl1), .wait_timeout(wt1)
  );

  mcycle_seq #(
    .CLK_PER_PHASE(3), .MAX_CYCLES(MAXC), .WAIT_MAX(WMAX)
  ) dut3 (
    .clk(clk), .reset(rst3), .decode_valid(1'b1),
    .cycles_decoded(2'd1), .movx(1'b0), .ready(1'b1),
    .phase(ph3), .state(s3), .cyc_left(cl3),
    .first_cyc(fc3), .state_tick(stk3),
    .instr_start(is3), .ale(ale3), .psen(ps3),
    .stalled(sl3), .wait_timeout(wt3)
  );

  // Model: state number 1..6, clk count inside the state,
  // machine cycles left, first-cycle flag, held states.
  int m_k[2], m_s[2], m_left[2], m_first[2], m_hold[2];
  int m_rs[2], m_stk[2], m_is[2], m_wt[2], m_sl[2];
  int m_ale[2], m_ps[2], pcnt[2], plast[2];
  bit m_mv[2];

  function automatic int code(input int s);
    case (s)
      1:       return 1;
      2:       return 3;
      3:       return 2;
      4:       return 0;
      5:       return 4;
      default: return 5;
    endcase
  endfunction

  task automatic chk(string nm, int d, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d t=%0t",
               nm, d, act, exp, $time);
    end
  endtask

  task automatic model_step(int d, int cpp, int rst, int dv,
                            int cd, int mx, int rdy);
    int ph, lo;
    bit wpt;
    m_stk[d] = 0;
    m_is[d]  = 0;
    m_wt[d]  = 0;
    if (rst != 0) begin
      m_s[d] = 6; m_k[d] = 0; m_left[d] = 0;
      m_first[d] = 0; m_hold[d] = 0; m_sl[d] = 0;
      m_rs[d] = 1; m_mv[d] = 1'b1;
      m_ale[d] = 0; m_ps[d] = 1;
      return;
    end
    m_rs[d] = 0;
    if (m_k[d] < 2 * cpp - 1) begin
      m_k[d]++;
    end else begin
      m_k[d] = 0;
      if (m_s[d] == 1 && m_first[d] != 0)
        m_left[d] = (dv == 0) ? 0 :
                    (cd > MAXC - 1) ? MAXC - 1 : cd;
      wpt = WEN && (m_s[d] == 3 || m_s[d] == 6) && rdy == 0;
      if (wpt && m_hold[d] < WMAX) begin
        m_hold[d]++;
        m_sl[d] = 1;
      end else begin
        if (wpt) m_wt[d] = 1;
        m_hold[d] = 0; m_sl[d] = 0; m_stk[d] = 1;
        if (m_s[d] == 6) begin
          if (m_left[d] == 0) m_first[d] = 1;
          else begin m_left[d]--; m_first[d] = 0; end
          m_s[d] = 1;
        end else begin
          m_s[d]++;
        end
        if (m_s[d] == 1 && m_first[d] != 0) m_is[d] = 1;
      end
    end
    ph = (m_k[d] >= cpp) ? 1 : 0;
    m_ale[d] = ((m_s[d] == 1 && !(mx != 0 &&
                 m_first[d] == 0 && m_left[d] == 0)) ||
                m_s[d] == 4) ? 1 : 0;
    lo = 0;
    if (((m_s[d] == 2 && ph != 0) || m_s[d] == 3) &&
        !(mx != 0 && m_first[d] == 0)) lo = 1;
    if (((m_s[d] == 5 && ph != 0) || m_s[d] == 6) &&
        !(mx != 0 && m_first[d] != 0 && m_left[d] != 0))
      lo = 1;
    m_ps[d] = 1 - lo;
  endtask

  task automatic cmp(int d, int cpp, int ph, int st, int cl,
                     int fc, int stk, int is, int al, int ps,
                     int sl, int wt);
    chk("phase", d, ph, (m_k[d] >= cpp) ? 1 : 0);
    chk("state", d, st, code(m_s[d]));
    chk("cyc_left", d, cl, m_left[d]);
    chk("first_cyc", d, fc, m_first[d]);
    chk("state_tick", d, stk, m_stk[d]);
    chk("instr_start", d, is, m_is[d]);
    chk("ale", d, al, m_ale[d]);
    chk("psen", d, ps, m_ps[d]);
    chk("stalled", d, sl, m_sl[d]);
    chk("wait_timeout", d, wt, m_wt[d]);
    if (m_rs[d] != 0) begin
      pcnt[d] = 1; plast[d] = ph;
    end else if (ph != plast[d]) begin
      chk("phase_period", d, pcnt[d], cpp);
      pcnt[d] = 1; plast[d] = ph;
    end else begin
      pcnt[d]++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0, 1, rst1, dv1, cd1, mx1, rdy1);
    model_step(1, 3, rst3, 1, 1, 0, 1);
  end

  initial forever begin
    @(negedge clk);
    if (m_mv[0])
      cmp(0, 1, ph1, s1, cl1, fc1, stk1, is1,
          ale1, ps1, sl1, wt1);
    if (m_mv[1])
      cmp(1, 3, ph3, s3, cl3, fc3, stk3, is3,
          ale3, ps3, sl3, wt3);
  end

  task automatic wait_is(int d, int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((d == 0) ? !is1 : !is3) && n < lim);
    chk("istart_wait", d, (d == 0) ? is1 : is3, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, a, p, sc, wc, wi;
    logic [2:0] wide;
    int al[24];
    int pn[24];
    int sv[16];
    rst1 = 1'b1; rst3 = 1'b1;
    dv1 = 1'b1; cd1 = '0; mx1 = 1'b0; rdy1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 0, s1, 5);
    chk("rst_phase", 0, ph1, 0);
    chk("rst_cyc_left", 0, cl1, 0);
    chk("rst_first", 0, fc1, 0);
    chk("rst_ale", 0, ale1, 0);
    chk("rst_psen", 0, ps1, 1);
    chk("rst_istart", 0, is1, 0);
    chk("rst_stalled", 0, sl1, 0);
    rst1 = 1'b0; rst3 = 1'b0;

    // CLK_PER_PHASE=3, one extra cycle: 72 clk period
    wait_is(1, 40);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 6)  chk("cpp3_left_c1", 1, cl3, 1);
      if (n == 42) chk("cpp3_left_c2", 1, cl3, 0);
    end while (!is3 && n < 200);
    chk("cpp3_period", 1, n, 72);

    // single-cycle instruction: strobes per 12 clks
    wait_is(0, 30);
    a = 0; p = 0;
    for (int i = 0; i < 12; i++) begin
      if (ale1) a++;
      if (!ps1) p++;
      @(negedge clk);
    end
    chk("ale_clks", 0, a, 4);
    chk("psen_low_clks", 0, p, 6);
    chk("period_12", 0, is1, 1);

    // 3'b111 truncated into the 2-bit port
    wide = 3'b111;
    cd1 = wide[CW-1:0];
    repeat (2) @(negedge clk);
    chk("cd3_left", 0, cl1, 3);
    n = 2;
    do begin
      @(negedge clk);
      n++;
    end while (!is1 && n < 100);
    chk("cd3_period", 0, n, 48);

    // movx two-cycle instruction
    cd1 = 2'd1; mx1 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      al[i] = ale1;
      pn[i] = ps1;
      @(negedge clk);
    end
    chk("mx_period", 0, is1, 1);
    chk("mx_ale_c1s1", 0, al[0], 1);
    chk("mx_ale_c2s1a", 0, al[12], 0);
    chk("mx_ale_c2s1b", 0, al[13], 0);
    chk("mx_ale_c2s4", 0, al[18], 1);
    chk("mx_psen_c1s3", 0, pn[4], 0);
    chk("mx_psen_c1s6", 0, pn[10], 1);
    chk("mx_psen_c2s2p2", 0, pn[15], 1);
    chk("mx_psen_c2s3", 0, pn[16], 1);
    chk("mx_psen_c2s5p2", 0, pn[21], 0);
    chk("mx_psen_c2s6", 0, pn[23], 0);

    // reset in S4 of machine cycle 2
    mx1 = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_rst_state", 0, s1, 0);
    chk("pre_rst_left", 0, cl1, 0);
    chk("pre_rst_ale", 0, ale1, 1);
    rst1 = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 0, s1, 5);
    chk("mid_rst_left", 0, cl1, 0);
    chk("mid_rst_ale", 0, ale1, 0);
    chk("mid_rst_psen", 0, ps1, 1);
    rst1 = 1'b0; cd1 = '0;

`ifdef MCYCLE_WAIT_STATE_EN
    // ready low at two S3 advance points
    wait_is(0, 30);
    sc = 0;
    for (int i = 0; i < 16; i++) begin
      sv[i] = s1;
      if (sl1) sc++;
      if (i == 4) rdy1 = 1'b0;
      if (i == 8) rdy1 = 1'b1;
      @(negedge clk);
    end
    chk("hold_stall_clks", 0, sc, 4);
    chk("hold_s3_last", 0, sv[9], 2);
    chk("hold_s4", 0, sv[10], 0);
    chk("hold_period", 0, is1, 1);

    // ready stuck low until forced advance
    rdy1 = 1'b0;
    sc = 0; wc = 0; wi = -1; n = 0;
    do begin
      if (sl1) sc++;
      if (wt1) begin
        wc++;
        if (wi < 0) wi = n;
        rdy1 = 1'b1;
      end
      @(negedge clk);
      n++;
    end while (!is1 && n < 120);
    chk("to_stall_clks", 0, sc, 30);
    chk("to_pulses", 0, wc, 1);
    chk("to_at", 0, wi, 36);
    chk("to_period", 0, n, 42);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcycle_seq.md
MCYCLE_SEQ -- requirements
Module: mcycle_seq

Interface
REQ-001 Parameter CLK_PER_PHASE, default 1: clk cycles per phase; legal range 1..16.
REQ-002 Parameter MAX_CYCLES, default 4: maximum machine cycles per instruction; legal range 2..16.
REQ-003 Parameter WAIT_MAX, default 15: maximum wait states per bus state before forced advance.
REQ-004 Port clk, input, 1: single clock; all state SHALL change on posedge clk.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port decode_valid, input, 1: opcode decoded; cycles_decoded is valid.
REQ-007 Port cycles_decoded, input, CW: extra machine cycles needed by the instruction, where CW = $clog2(MAX_CYCLES).
REQ-008 Port movx, input, 1: the current instruction is an external-data move.
REQ-009 Port ready, input, 1: external bus ready; used only with WAIT_STATE_EN.
REQ-010 Port phase, output, 1: 0 = P1, 1 = P2.
REQ-011 Port state, output, 3: S-state encoding, defined in REQ-039.
REQ-012 Port cyc_left, output, CW: machine cycles remaining after the current one.
REQ-013 Port first_cyc, output, 1: the current machine cycle is the instruction's first.
REQ-014 Port state_tick, output, 1: one-clk pulse on each S-state advance.
REQ-015 Port instr_start, output, 1: one-clk pulse on entry to S1 with first_cyc = 1.
REQ-016 Port ale, output, 1: address latch enable, active high.
REQ-017 Port psen, output, 1: program strobe, active low.
REQ-018 Port stalled, output, 1: a wait state is in progress.
REQ-019 Port wait_timeout, output, 1: one-clk pulse when a wait is forced to end.

Function
REQ-020 Prescaler pre SHALL count 0..CLK_PER_PHASE-1 and wrap; tick = (pre == CLK_PER_PHASE-1).
REQ-021 phase SHALL toggle on every tick, with no exception, including during stalls.
REQ-022 On a tick with phase = 1, state SHALL advance S1→S2→S3→S4→S5→S6→S1 unless held by REQ-031.
- state_tick SHALL pulse on the same clk as the advance.
REQ-023 At end of S1P2 with first_cyc = 1:
- cyc_left SHALL load min(cycles_decoded, MAX_CYCLES-1).
- If decode_valid = 0, cyc_left SHALL load 0.
REQ-024 At end of S6P2:
- If cyc_left = 0: first_cyc SHALL become 1.
- Otherwise: cyc_left SHALL decrement and first_cyc SHALL become 0.
REQ-025 instr_start SHALL pulse on the clk on which state becomes S1 with first_cyc = 1.
REQ-026 ale SHALL be 1 throughout S1 and S4, and 0 in all other states.
- Exception: ale SHALL be 0 in S1 when movx = 1, first_cyc = 0 and cyc_left = 0.
REQ-027 psen SHALL be 0 during S2P2, S3, S5P2 and S6, and 1 otherwise.
- S2P2/S3 pulse is suppressed when movx = 1 and first_cyc = 0.
- S5P2/S6 pulse is suppressed when movx = 1 and first_cyc = 1 and cyc_left ≠ 0.
REQ-028 All outputs SHALL be decoded from registered state only, with zero added latency; no input-to-output combinational path.
REQ-029 cycles_decoded values of MAX_CYCLES or greater SHALL saturate; no wrap.

Reset
REQ-030 On reset (at power-up or mid-operation), at the next posedge the block SHALL take these values:
- pre = 0, phase = 0, state = S6, cyc_left = 0, first_cyc = 0.
- ale = 0, psen = 1.
- state_tick = 0, instr_start = 0, stalled = 0, wait_timeout = 0.
- Wait counter = 0.
- The first S6 SHALL then end into S1 with first_cyc = 1.

Configuration
REQ-031 With macro MCYCLE_WAIT_STATE_EN defined:
- At the advance point out of S3 or S6, if ready = 0, state SHALL hold for a further P1/P2 pair.
- During the hold: stalled = 1 and psen keeps its S3/S6 value.
- The wait counter SHALL increment per held state.
- After WAIT_MAX held states, state SHALL advance regardless of ready, and wait_timeout SHALL pulse once.
- The wait counter SHALL clear on every advance.
REQ-032 Without the macro, ready SHALL be ignored, stalled and wait_timeout SHALL be tied 0, and no wait counter SHALL exist.

Structure
REQ-033 Package mcycle_pkg SHALL hold the S-state encoding constants and the CW width function.
REQ-034 Sub-module mcycle_prescaler (the pre counter and tick output) SHALL be the only sub-module.
REQ-035 The rest of the block SHALL be flat logic in mcycle_seq.
REQ-036 No latches; every register assignment SHALL be inside a posedge clk block with a synchronous reset branch.
REQ-039 State encodings: S1 = 001, S2 = 011, S3 = 010, S4 = 000, S5 = 100, S6 = 101.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- CLK_PER_PHASE = 1, cycles_decoded = 0: instr_start every 12 clks; ale high 4 clks in 12; psen low 3+3 clks.
- CLK_PER_PHASE = 3, cycles_decoded = 1: instr_start every 72 clks; cyc_left reads 1 then 0.
- movx = 1, cycles_decoded = 1: second cycle has ale = 0 in S1, no S2P2/S3 psen pulse, and S5P2/S6 psen pulse present.
- MAX_CYCLES = 4, cycles_decoded = 3'b111 (CW = 2 truncates to 3): cyc_left = 3, instruction lasts 4 machine cycles.
- MCYCLE_WAIT_STATE_EN, ready = 0 for 2 states at S3: S3 lasts 3 states; stalled high 4 clks. ready stuck 0 with WAIT_MAX = 15: forced advance after 15 held states, one wait_timeout pulse.
- reset asserted in S4 of cycle 2: next clk shows state = S6, cyc_left = 0, ale = 0, psen = 1.
REQ-038 The bench SHALL assert, for every test, that phase toggles exactly once per tick.
